// File: rtl/asrc_pkg.sv
// Shared definitions for the ASRC audio-path blocks.
//  - asrc_state_t : TDM sender FSM states (IDLE -> SEND -> GAP -> IDLE)
//  - CH_IDX_W     : width of a channel index on the FIR sink (up to MAX_NCH channels)
//  - asrc_scale() : arithmetic left shift followed by optional signed saturation
//                   to an out_w-bit range; evaluated on a 64-bit signed value so
//                   any block with sample widths below 64 bits can reuse it
package asrc_pkg;

    localparam int CH_IDX_W = 3;
    localparam int MAX_NCH  = 8;
    localparam int SCALE_W  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } asrc_state_t;

    // Returns x <<< shift. With sat_en set, a result outside the signed
    // out_w-bit range is clamped to its nearest limit; otherwise the caller
    // takes the low out_w bits and overflow wraps.
    function automatic logic signed [SCALE_W-1:0] asrc_scale(
        input logic signed [SCALE_W-1:0] x,
        input int                        shift,
        input int                        out_w,
        input logic                      sat_en
    );
        logic signed [SCALE_W-1:0] v;
        logic signed [SCALE_W-1:0] vmax;
        logic signed [SCALE_W-1:0] vmin;
        logic        [SCALE_W-1:0] one;
        one  = 1;
        v    = x <<< shift;
        vmax = $signed((one << (out_w - 1)) - one);
        vmin = -vmax - $signed(one);
        if (sat_en && (v > vmax)) begin
            v = vmax;
        end else if (sat_en && (v < vmin)) begin
            v = vmin;
        end
        return v;
    endfunction

endpackage

// File: rtl/asrc_tdm_collect.sv
// Back end of the TDM FIR mux: gathers the FIR source beats of one packet,
// scales each beat to OUT_W bits and publishes the whole frame at once.
//
// Ports
//  AMCLK_i      in   audio master clock, all logic on posedge
//  nARST        in   synchronous active-low reset
//  src_data_i   in   FIR source data (signed, FIR_W)
//  src_valid_i  in   FIR source beat valid
//  src_sop_i    in   first beat of a packet (restarts collection at ch0)
//  src_eop_i    in   last beat of a packet
//  out_data_o   out  collected frame, ch k at [k*OUT_W +: OUT_W]
//  out_valid_o  out  one-cycle strobe, out_data_o changes in the same cycle
//  frame_err_o  out  sticky: a malformed packet or stray beat was discarded
//
// Build option: define ASRC_TDM_SAT_EN to clamp out-of-range scaled samples
// instead of letting them wrap.
module asrc_tdm_collect
    import asrc_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int FIR_W     = 24,
    parameter int OUT_W     = 24,
    parameter int OUT_SHIFT = 4
) (
    input  logic                 AMCLK_i,
    input  logic                 nARST,
    input  logic [FIR_W-1:0]     src_data_i,
    input  logic                 src_valid_i,
    input  logic                 src_sop_i,
    input  logic                 src_eop_i,
    output logic [NCH*OUT_W-1:0] out_data_o,
    output logic                 out_valid_o,
    output logic                 frame_err_o
);

`ifdef ASRC_TDM_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    // One extra bit so the index can rest at NCH between packets.
    localparam int IDX_W = CH_IDX_W + 1;
    localparam logic [IDX_W-1:0] NCH_IDX  = IDX_W'(NCH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    logic [IDX_W-1:0]          idx_reg;
    logic [IDX_W-1:0]          idx_next;
    logic [IDX_W-1:0]          beat_idx;
    logic [NCH*OUT_W-1:0]      shadow_reg;
    logic [NCH*OUT_W-1:0]      shadow_next;
    logic [NCH*OUT_W-1:0]      out_data_reg;
    logic                      out_valid_reg;
    logic                      frame_err_reg;
    logic signed [SCALE_W-1:0] src_ext;
    logic signed [SCALE_W-1:0] scaled_wide;
    logic [OUT_W-1:0]          scaled;
    logic                      beat_ok;
    logic                      frame_done;
    logic                      frame_bad;
    logic                      unused_scale_bits;

    assign src_ext     = {{(SCALE_W - FIR_W){src_data_i[FIR_W-1]}}, src_data_i};
    assign scaled_wide = asrc_scale(src_ext, OUT_SHIFT, OUT_W, SAT_EN);
    assign scaled      = scaled_wide[OUT_W-1:0];
    assign unused_scale_bits = ^scaled_wide[SCALE_W-1:OUT_W];

    // sop always restarts at ch0, whatever the previous packet left behind.
    assign beat_idx   = src_sop_i ? '0 : idx_reg;
    assign beat_ok    = src_valid_i && (beat_idx < NCH_IDX);
    assign frame_done = beat_ok && src_eop_i && (beat_idx == LAST_IDX);
    assign frame_bad  = src_valid_i && (!beat_ok || (src_eop_i && (beat_idx != LAST_IDX)));

    // shadow_next is the shadow with the current beat's lane replaced, so the
    // eop beat lands in the published frame in the same edge.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
            assign shadow_next[gi*OUT_W +: OUT_W] =
                (beat_idx == IDX_W'(gi)) ? scaled : shadow_reg[gi*OUT_W +: OUT_W];
        end
    endgenerate

    always_comb begin
        idx_next = idx_reg;
        if (src_valid_i) begin
            if (src_eop_i) begin
                idx_next = NCH_IDX;
            end else if (beat_ok) begin
                idx_next = beat_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge AMCLK_i) begin
        if (!nARST) begin
            idx_reg       <= '0;
            shadow_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            idx_reg       <= idx_next;
            out_valid_reg <= frame_done;
            if (beat_ok) begin
                shadow_reg <= shadow_next;
            end
            if (frame_done) begin
                out_data_reg <= shadow_next;
            end
            if (frame_bad) begin
                frame_err_reg <= 1'b1;
            end
        end
    end

    assign out_data_o  = out_data_reg;
    assign out_valid_o = out_valid_reg;
    assign frame_err_o = frame_err_reg;

endmodule

// File: rtl/asrc_tdm_fir_mux.sv
// TDM front/back end for the shared multichannel FIR interpolator.
// Front end: a parallel PCM frame is serialised as one sop..eop packet,
// ch0 first, one beat per cycle, followed by GAP_CYCLES forced idle cycles.
// A 1-deep pending slot absorbs one frame arriving while a packet is in
// flight; a further frame is dropped and flagged. Back end: see
// asrc_tdm_collect.
//
// Ports
//  AMCLK_i       in   audio master clock, all logic on posedge
//  nARST         in   synchronous active-low reset
//  in_data_i     in   input frame, ch k at [k*IN_W +: IN_W]
//  in_valid_i    in   one-cycle frame strobe
//  sink_data_o   out  FIR sink data
//  sink_valid_o  out  FIR sink valid
//  sink_sop_o    out  high with ch0
//  sink_eop_o    out  high with ch NCH-1
//  sink_chan_o   out  channel index of current beat
//  src_*_i       in   FIR source beat (data/valid/sop/eop)
//  out_data_o    out  collected, scaled frame
//  out_valid_o   out  one-cycle strobe with out_data_o update
//  overrun_o     out  sticky: an input frame was dropped
//  frame_err_o   out  sticky: a malformed source packet was discarded
//
// Build option: ASRC_TDM_SAT_EN selects saturating output scaling.
module asrc_tdm_fir_mux
    import asrc_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int IN_W       = 16,
    parameter int FIR_W      = 24,
    parameter int OUT_W      = 24,
    parameter int OUT_SHIFT  = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 AMCLK_i,
    input  logic                 nARST,
    input  logic [NCH*IN_W-1:0]  in_data_i,
    input  logic                 in_valid_i,
    output logic [IN_W-1:0]      sink_data_o,
    output logic                 sink_valid_o,
    output logic                 sink_sop_o,
    output logic                 sink_eop_o,
    output logic [2:0]           sink_chan_o,
    input  logic [FIR_W-1:0]     src_data_i,
    input  logic                 src_valid_i,
    input  logic                 src_sop_i,
    input  logic                 src_eop_i,
    output logic [NCH*OUT_W-1:0] out_data_o,
    output logic                 out_valid_o,
    output logic                 overrun_o,
    output logic                 frame_err_o
);

    localparam logic [CH_IDX_W-1:0] LAST_CH  = CH_IDX_W'(NCH - 1);
    localparam logic [3:0]          GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    asrc_state_t          state_reg;
    asrc_state_t          state_next;
    logic [CH_IDX_W-1:0]  chan_reg;
    logic [CH_IDX_W-1:0]  chan_next;
    logic [3:0]           gap_reg;
    logic [3:0]           gap_next;
    logic [NCH*IN_W-1:0]  frame_reg;
    logic [NCH*IN_W-1:0]  frame_next;
    logic [NCH*IN_W-1:0]  pend_data_reg;
    logic [NCH*IN_W-1:0]  pend_data_next;
    logic                 pend_valid_reg;
    logic                 pend_valid_next;
    logic                 overrun_reg;
    logic                 overrun_next;
    logic [IN_W-1:0]      sel_data;

    always_ff @(posedge AMCLK_i) begin
        if (!nARST) begin
            state_reg      <= IDLE;
            chan_reg       <= '0;
            gap_reg        <= '0;
            frame_reg      <= '0;
            pend_data_reg  <= '0;
            pend_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            chan_reg       <= chan_next;
            gap_reg        <= gap_next;
            frame_reg      <= frame_next;
            pend_data_reg  <= pend_data_next;
            pend_valid_reg <= pend_valid_next;
            overrun_reg    <= overrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        chan_next       = chan_reg;
        gap_next        = gap_reg;
        frame_next      = frame_reg;
        pend_data_next  = pend_data_reg;
        pend_valid_next = pend_valid_reg;
        overrun_next    = overrun_reg;

        case (state_reg)
            IDLE: begin
                // The pending frame is older, so it goes first; a frame
                // arriving in the same cycle refills the slot behind it.
                if (pend_valid_reg) begin
                    frame_next = pend_data_reg;
                    state_next = SEND;
                    chan_next  = '0;
                    if (in_valid_i) begin
                        pend_data_next = in_data_i;
                    end else begin
                        pend_valid_next = 1'b0;
                    end
                end else if (in_valid_i) begin
                    frame_next = in_data_i;
                    state_next = SEND;
                    chan_next  = '0;
                end
            end
            SEND: begin
                if (chan_reg == LAST_CH) begin
                    chan_next  = '0;
                    gap_next   = '0;
                    state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else begin
                    chan_next = chan_reg + 1'b1;
                end
            end
            GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Frames arriving while a packet is in flight: keep the first,
        // drop any later one and keep the already-pending frame intact.
        if ((state_reg != IDLE) && in_valid_i) begin
            if (!pend_valid_reg) begin
                pend_valid_next = 1'b1;
                pend_data_next  = in_data_i;
            end else begin
                overrun_next = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (chan_reg == CH_IDX_W'(k)) begin
                sel_data = frame_reg[k*IN_W +: IN_W];
            end
        end
    end

    // Sink outputs decode straight from the state so that a frame latched at
    // an edge shows its ch0 beat in the very next cycle.
    assign sink_valid_o = (state_reg == SEND);
    assign sink_data_o  = sink_valid_o ? sel_data : '0;
    assign sink_sop_o   = sink_valid_o && (chan_reg == '0);
    assign sink_eop_o   = sink_valid_o && (chan_reg == LAST_CH);
    assign sink_chan_o  = sink_valid_o ? chan_reg : '0;
    assign overrun_o    = overrun_reg;

    asrc_tdm_collect #(
        .NCH       (NCH),
        .FIR_W     (FIR_W),
        .OUT_W     (OUT_W),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_collect (
        .AMCLK_i     (AMCLK_i),
        .nARST       (nARST),
        .src_data_i  (src_data_i),
        .src_valid_i (src_valid_i),
        .src_sop_i   (src_sop_i),
        .src_eop_i   (src_eop_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .frame_err_o (frame_err_o)
    );

endmodule
